// File: rtl/twophase_pkg.sv
// rtl/twophase_pkg.sv - shared state type, timeout default and round-robin picker for twophase_tx_arb
package twophase_pkg;

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   localparam int TP_DEFAULT_TIMEOUT = 1024;
   localparam int TP_MAX_N           = 32;

   // One-hot grant: first set bit of valid at or above ptr, wrapping at n.
   function automatic logic [TP_MAX_N-1:0] rr_pick(input logic [TP_MAX_N-1:0] valid,
                                                   input logic [4:0]          ptr,
                                                   input int unsigned         n);
      logic [TP_MAX_N-1:0] g;
      logic [5:0]          idx;
      g = '0;
      for (int unsigned k = 0; k < TP_MAX_N; k++) begin
         idx = {1'b0, ptr} + 6'(k);
         if (32'(idx) >= n) idx = idx - 6'(n);
         if (k < n && g == '0 && valid[idx[4:0]]) g[idx[4:0]] = 1'b1;
      end
      return g;
   endfunction

endpackage

// File: rtl/tp_ack_sync.sv
// rtl/tp_ack_sync.sv - two-flop synchroniser for the two-phase ack with toggle event detect
module tp_ack_sync (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_ack,
   output logic o_ack_evt,
   output logic o_ack_lvl
);

   logic r_s1;
   logic r_s2;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= i_ack;
         r_s2 <= r_s1;
      end
   end

   assign o_ack_evt = r_s1 ^ r_s2;
   assign o_ack_lvl = r_s2;

endmodule

// File: rtl/twophase_tx_arb.sv
// rtl/twophase_tx_arb.sv - round-robin arbiter feeding one two-phase link; optional ack timeout via TWOPHASE_ACK_TIMEOUT_EN
module twophase_tx_arb
   import twophase_pkg::*;
#(
   parameter int N           = 4,
   parameter int W           = 8,
   parameter int TIMEOUT_CYC = TP_DEFAULT_TIMEOUT,
   localparam int PW         = $clog2((N > 1) ? N : 2)
) (
   input  logic            clk,
   input  logic            _rst,
   input  logic [N-1:0]    req_valid,
   input  logic [N*W-1:0]  req_data,
   output logic [N-1:0]    req_ready,
   output logic [W-1:0]    tx_data,
   output logic            tx_req,
   input  logic            tx_ack,
   output logic            busy,
   output logic [PW-1:0]   grant_id
`ifdef TWOPHASE_ACK_TIMEOUT_EN
   ,
   input  logic            err_clr,
   output logic            err_timeout
`endif
);

   if (N < 1 || N > TP_MAX_N) begin : g_bad_n
      $error("N must be in 1..32");
   end
   if (TIMEOUT_CYC < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be at least 2");
   end

   state_t               r_state;
   state_t               w_state_nxt;
   logic [PW-1:0]        r_ptr;
   logic [W-1:0]         r_tx_data;
   logic                 r_tx_req;
   logic                 r_busy;
   logic [PW-1:0]        r_grant_id;
   logic [TP_MAX_N-1:0]  w_valid_ext;
   logic [TP_MAX_N-1:0]  w_pick;
   logic [N-1:0]         w_grant;
   logic                 w_do_grant;
   logic [PW-1:0]        w_gidx;
   logic [W-1:0]         w_gdata;
   logic                 w_ack_evt;
   logic                 w_ack_lvl;
   logic                 w_timeout;
   logic                 w_release;

   tp_ack_sync u_ack_sync (
      .i_clk     (clk),
      .i_rst_n   (_rst),
      .i_ack     (tx_ack),
      .o_ack_evt (w_ack_evt),
      .o_ack_lvl (w_ack_lvl)
   );

   // Grant is suppressed while reset is asserted so req_ready reads zero then.
   always_comb begin
      w_valid_ext            = '0;
      w_valid_ext[N-1:0]     = req_valid;
      w_pick                 = rr_pick(w_valid_ext, 5'(r_ptr), 32'(N));
      w_grant                = (r_state == IDLE && _rst) ? w_pick[N-1:0] : '0;
      w_gidx                 = '0;
      w_gdata                = '0;
      for (int i = 0; i < N; i++) begin
         if (w_grant[i]) begin
            w_gidx  = PW'(i);
            w_gdata = req_data[i*W +: W];
         end
      end
   end

   assign w_do_grant = |w_grant;
   assign w_release  = (r_state == WAIT) && (w_ack_evt || w_timeout);

`ifdef TWOPHASE_ACK_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC);
   logic [CW-1:0] r_cnt;
   logic          r_err;

   assign w_timeout   = (r_state == WAIT) && !w_ack_evt && (r_cnt == CW'(TIMEOUT_CYC - 1));
   assign err_timeout = r_err;

   always_ff @(posedge clk) begin
      if (!_rst) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_do_grant) r_cnt <= '0;
         else if (r_state == WAIT) r_cnt <= r_cnt + 1'b1;
         if (w_timeout) r_err <= 1'b1;
         else if (err_clr) r_err <= 1'b0;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_do_grant) w_state_nxt = WAIT;
         WAIT:    if (w_release) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!_rst) begin
         r_state    <= IDLE;
         r_ptr      <= '0;
         r_tx_data  <= '0;
         r_tx_req   <= 1'b0;
         r_busy     <= 1'b0;
         r_grant_id <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_do_grant) begin
            r_tx_data  <= w_gdata;
            r_tx_req   <= ~r_tx_req;
            r_grant_id <= w_gidx;
            r_ptr      <= (32'(w_gidx) == N - 1) ? '0 : w_gidx + 1'b1;
            r_busy     <= 1'b1;
         end else if (w_release) begin
            r_busy <= 1'b0;
         end
      end
   end

   assign req_ready = w_grant;
   assign tx_data   = r_tx_data;
   assign tx_req    = r_tx_req ^ (w_ack_lvl & 1'b0);
   assign busy      = r_busy;
   assign grant_id  = r_grant_id;

endmodule
